// File: rtl/seed_pkg.sv
// Shared definitions for the SEED round sequencer: FSM states, round limits,
// mode encodings and the round-index endpoints for each direction.
package seed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seed_state_e;

    localparam int SEED_ROUNDS_MAX = 16;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Decryption walks the key schedule backwards, so the endpoints swap.
    function automatic logic [3:0] seed_first_idx(input logic mode_i, input int rounds);
        if (mode_i == MODE_DEC) begin
            return 4'(rounds - 1);
        end else begin
            return 4'd0;
        end
    endfunction

    function automatic logic [3:0] seed_last_idx(input logic mode_i, input int rounds);
        if (mode_i == MODE_DEC) begin
            return 4'd0;
        end else begin
            return 4'(rounds - 1);
        end
    endfunction

endpackage

// File: rtl/seed_phase_counter.sv
// Modulo-STEP_CYCLES sub-cycle counter with a registered terminal-count strobe.
// tc_force_i lets the sequencer raise the strobe outside the counting window.
module seed_phase_counter #(
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic       tc_en_i,
    input  logic       tc_force_i,
    output logic [3:0] count_o,
    output logic       tc_o
);

    localparam logic [3:0] LAST = 4'(STEP_CYCLES - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       tc_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (adv_i) begin
            if (count_q == LAST) begin
                count_d = 4'd0;
            end else begin
                count_d = count_q + 4'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // The strobe is computed from the next count so it lines up with the phase it marks.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
            tc_q    <= 1'b0;
        end else if (en_i) begin
            count_q <= count_d;
            tc_q    <= tc_force_i | (tc_en_i & (count_d == LAST));
        end else begin
            count_q <= count_q;
            tc_q    <= tc_q;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/seed_round_ctrl.sv
// SEED round sequencer: turns one go request into ROUNDS x STEP_CYCLES enabled cycles.
// Define SEED_ROUND_CTRL_DECRYPT_EN to honour the mode input (descending rounds).
module seed_round_ctrl
    import seed_pkg::*;
#(
    parameter int ROUNDS      = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       go,
    input  logic       mode,
    output logic       start,
    output logic       sync,
    output logic       load,
    output logic [3:0] round_idx,
    output logic [3:0] phase,
    output logic       busy,
    output logic       done
);

    seed_state_e state_q;
    logic [3:0]  round_q;
    logic        start_q;
    logic        load_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  round_step_s;
    logic [3:0]  first_idx_s;
    logic [3:0]  last_idx_s;
    logic        sync_s;
    logic        run_last_s;
    logic        ctr_clr_s;
    logic        ctr_adv_s;
    logic        ctr_tc_en_s;
    logic        ctr_force_s;

`ifdef SEED_ROUND_CTRL_DECRYPT_EN
    logic mode_q;

    // Mode is frozen at acceptance so later toggles cannot disturb a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_ENC;
        end else if (clk_en && (state_q == ST_IDLE) && go) begin
            mode_q <= mode;
        end else begin
            mode_q <= mode_q;
        end
    end

    assign round_step_s = (mode_q == MODE_DEC) ? (round_q - 4'd1) : (round_q + 4'd1);
    assign first_idx_s  = seed_first_idx(mode, ROUNDS);
    assign last_idx_s   = seed_last_idx(mode_q, ROUNDS);
`else
    logic unused_mode_s;

    assign unused_mode_s = mode;
    assign round_step_s  = round_q + 4'd1;
    assign first_idx_s   = 4'd0;
    assign last_idx_s    = 4'(ROUNDS - 1);
`endif

    assign run_last_s = (state_q == ST_RUN) && sync_s && (round_q == last_idx_s);

    // Phase counter steering: held cleared outside RUN, strobe forced for the LOAD capture.
    always_comb begin
        ctr_clr_s   = 1'b1;
        ctr_adv_s   = 1'b0;
        ctr_tc_en_s = 1'b0;
        ctr_force_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ctr_force_s = go;
            end
            ST_LOAD: begin
                ctr_tc_en_s = 1'b1;
            end
            ST_RUN: begin
                if (run_last_s) begin
                    ctr_clr_s = 1'b1;
                end else begin
                    ctr_clr_s   = 1'b0;
                    ctr_adv_s   = 1'b1;
                    ctr_tc_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                ctr_clr_s = 1'b1;
            end
            default: begin
                ctr_clr_s = 1'b1;
            end
        endcase
    end

    seed_phase_counter #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_phase (
        .clk       (clk),
        .reset     (reset),
        .en_i      (clk_en),
        .clr_i     (ctr_clr_s),
        .adv_i     (ctr_adv_s),
        .tc_en_i   (ctr_tc_en_s),
        .tc_force_i(ctr_force_s),
        .count_o   (phase),
        .tc_o      (sync_s)
    );

    // Sequencer FSM with registered strobes and round index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            start_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_LOAD;
                        round_q <= first_idx_s;
                        start_q <= 1'b1;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        round_q <= 4'd0;
                        start_q <= 1'b0;
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_RUN;
                    start_q <= 1'b1;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
                ST_RUN: begin
                    if (run_last_s) begin
                        state_q <= ST_DONE;
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (sync_s) begin
                        round_q <= round_step_s;
                    end else begin
                        round_q <= round_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    round_q <= 4'd0;
                    start_q <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    round_q <= 4'd0;
                    start_q <= 1'b0;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign start     = start_q;
    assign sync      = sync_s;
    assign load      = load_q;
    assign round_idx = round_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Scoreboard bench for seed_round_ctrl: default build and a ROUNDS=2/STEP_CYCLES=1 build.
module tb_seed_round_ctrl;

    typedef struct packed {
        logic       start;
        logic       sync;
        logic       load;
        logic       busy;
        logic       done;
        logic [3:0] round;
        logic [3:0] phase;
    } exp_t;

`ifdef SEED_ROUND_CTRL_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam exp_t IDLE_EXP = '0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b1;
    logic       go = 1'b0;
    logic       mode = 1'b0;

    logic       start_a, sync_a, load_a, busy_a, done_a;
    logic [3:0] round_a, phase_a;
    logic       start_b, sync_b, load_b, busy_b, done_b;
    logic [3:0] round_b, phase_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur_a = IDLE_EXP;
    exp_t cur_b = IDLE_EXP;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    seed_round_ctrl dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .go(go), .mode(mode),
        .start(start_a), .sync(sync_a), .load(load_a), .round_idx(round_a),
        .phase(phase_a), .busy(busy_a), .done(done_a)
    );

    seed_round_ctrl #(.ROUNDS(2), .STEP_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .go(go), .mode(mode),
        .start(start_b), .sync(sync_b), .load(load_b), .round_idx(round_b),
        .phase(phase_b), .busy(busy_b), .done(done_b)
    );

    task automatic push_exp(input int inst, input exp_t e);
        if (inst == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // Expected per-enabled-cycle outputs from LOAD through DONE for one accepted go.
    task automatic push_run(input int inst, input logic m, input int r, input int s);
        exp_t e;
        logic md;
        md = m & DEC_EN;
        e = IDLE_EXP;
        e.start = 1'b1; e.sync = 1'b1; e.load = 1'b1; e.busy = 1'b1;
        e.round = md ? 4'(r - 1) : 4'd0;
        push_exp(inst, e);
        for (int rr = 0; rr < r; rr++) begin
            for (int pp = 0; pp < s; pp++) begin
                e = IDLE_EXP;
                e.start = 1'b1;
                e.busy  = 1'b1;
                e.sync  = (pp == s - 1);
                e.round = md ? 4'(r - 1 - rr) : 4'(rr);
                e.phase = 4'(pp);
                push_exp(inst, e);
            end
        end
        e = IDLE_EXP;
        e.busy  = 1'b1;
        e.done  = 1'b1;
        e.round = md ? 4'd0 : 4'(r - 1);
        push_exp(inst, e);
    endtask

    task automatic check(input string tag, input exp_t obs, input exp_t expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic g, input logic m);
        reset  = rst;
        clk_en = en;
        go     = g;
        mode   = m;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            cur_a = IDLE_EXP;
            cur_b = IDLE_EXP;
        end else if (en) begin
            if (g && (q_a.size() == 0) && !cur_a.busy) push_run(0, m, 16, 4);
            if (g && (q_b.size() == 0) && !cur_b.busy) push_run(1, m, 2, 1);
            if (q_a.size() > 0) cur_a = q_a.pop_front();
            else cur_a = IDLE_EXP;
            if (q_b.size() > 0) cur_b = q_b.pop_front();
            else cur_b = IDLE_EXP;
        end
        #1;
        check("dflt", {start_a, sync_a, load_a, busy_a, done_a, round_a, phase_a}, cur_a);
        check("r2s1", {start_b, sync_b, load_b, busy_b, done_b, round_b, phase_b}, cur_b);
    endtask

    initial begin
        logic en_r;
        logic m_r;
        exp_t mid;

        // Reset state, including reset winning over a simultaneous go.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);

        // Encrypt run with continuous clock enable.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Decrypt request; mode toggles after acceptance must not matter.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (50) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Pseudo-random clock enable stretches the schedule.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            en_r = 1'($urandom_range(0, 1));
            m_r  = 1'($urandom_range(0, 1));
            step(1'b0, en_r, 1'b0, m_r);
        end
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of round 7, phase 2, then a fresh start.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (31) step(1'b0, 1'b1, 1'b0, 1'b0);
        mid = IDLE_EXP;
        mid.start = 1'b1; mid.busy = 1'b1; mid.round = 4'd7; mid.phase = 4'd2;
        check("mid_run_pos", {start_a, sync_a, load_a, busy_a, done_a, round_a, phase_a}, mid);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);

        // go held high: a new run only begins at the first IDLE cycle.
        repeat (150) step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);

        checks++;
        assert (q_a.size() === 0) else begin
            failures++;
            $error("FAIL drain_a observed=%0d expected=0", q_a.size());
        end
        checks++;
        assert (q_b.size() === 0) else begin
            failures++;
            $error("FAIL drain_b observed=%0d expected=0", q_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seed_round_ctrl.md
# seed_round_ctrl

Round sequencer for the SEED datapath. Generates the `start`/`sync` strobes that drive the 32-bit synchronous data registers, a one-shot `load` for plaintext capture, and the round index consumed by the key schedule. It sits directly upstream of the round registers and key-schedule lookup. It converts a single `go` request into ROUNDS rounds of STEP_CYCLES clock-enabled cycles each, ending with a `done` pulse.

## Interface
- ROUNDS, 16: number of SEED rounds; legal range 2..16.
- STEP_CYCLES, 4: enabled cycles per round (F-function latency); legal range 1..16.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; overrides every other input.
- clk_en  in  1  global clock enable; when low, all state and outputs hold.
- go  in  1  start request; sampled only in IDLE with clk_en high.
- mode  in  1  0 = encrypt, 1 = decrypt; latched when `go` is accepted.
- start  out  1  high from LOAD through the last RUN cycle; feeds the register `start` input.
- sync  out  1  register capture strobe; one enabled cycle wide per event.
- load  out  1  high only in LOAD; selects plaintext into the data registers.
- round_idx  out  4  current round number for the key schedule.
- phase  out  4  sub-cycle within the current round, 0..STEP_CYCLES-1.
- busy  out  1  high in LOAD, RUN and DONE.
- done  out  1  one-enabled-cycle pulse after the final round capture.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Every transition and counter update is qualified by clk_en. All outputs are registered.
- **IDLE**
  - All outputs are 0; round_idx = 0.
  - `go`=1 latches mode and moves to LOAD.
- **LOAD** (one enabled cycle)
  - start=1, sync=1, load=1, phase=0.
  - round_idx = 0 (encrypt) or ROUNDS-1 (decrypt).
  - Moves to RUN.
- **RUN**
  - phase counts 0..STEP_CYCLES-1 and wraps to 0.
  - sync=1 exactly when phase = STEP_CYCLES-1.
  - On the edge leaving a sync cycle, round_idx steps +1 (encrypt) or -1 (decrypt).
  - The sync cycle of the last round (idx ROUNDS-1 encrypt, 0 decrypt) exits to DONE; round_idx does not step past the final value.
- **DONE** (one enabled cycle)
  - done=1, start=0, sync=0.
  - round_idx holds its final value.
  - Moves to IDLE, where round_idx returns to 0.
- STEP_CYCLES=1: phase stays 0 and sync is high on every RUN cycle.
- `go` outside IDLE is ignored; it is not queued.
- `mode` changes after acceptance have no effect.
- reset at any time (including mid-RUN): next state IDLE, all outputs 0, phase 0, round_idx 0, latched mode 0.
- reset and `go` in the same cycle: reset wins.
- clk_en low: no state change. Pulses (sync, load, done) stay asserted until the next enabled cycle, so each pulse spans exactly one enabled cycle.

## Timing
- `go` accepted at enabled cycle T.
  - LOAD outputs visible in cycle T+1.
  - RUN covers T+2 .. T+1+ROUNDS·STEP_CYCLES.
  - done is high in T+2+ROUNDS·STEP_CYCLES (T+66 for the defaults).
- Enabled cycles are counted; disabled cycles stretch the schedule without changing it.
- Minimum spacing between two accepted `go`s: ROUNDS·STEP_CYCLES+3 enabled cycles.
- round_idx is stable for STEP_CYCLES enabled cycles ending with its sync cycle.

## Configuration
- SEED_ROUND_CTRL_DECRYPT_EN
  - Defined: `mode` is honoured as described above.
  - Undefined: the `mode` port remains but is ignored; the sequence is always encrypt order; the mode latch and down-count logic are removed.

## Structure
- Shared package `seed_pkg` holds:
  - state enum (IDLE/LOAD/RUN/DONE);
  - SEED_ROUNDS_MAX = 16;
  - mode encodings MODE_ENC = 0, MODE_DEC = 1.
- Sub-module `seed_phase_counter`: a modulo-STEP_CYCLES counter with clear/enable inputs and a terminal-count output; it drives phase and sync.

## Test plan
- Reset release, `go`=1, mode=0, clk_en=1, defaults → LOAD at T+1; 16 sync pulses at T+5, T+9, …, T+65; round_idx 0→15; done at T+66.
- mode=1 (macro defined) → LOAD round_idx=15, decrementing to 0; done at T+66. With the macro undefined, same stimulus → ascending 0..15.
- clk_en toggled 50% pseudo-random → same sync count and order; each pulse spans exactly one enabled cycle; done after 66 enabled cycles.
- reset asserted at RUN round 7, phase 2 → next cycle: all outputs 0, IDLE; a fresh `go` restarts at round_idx 0.
- `go` held high through the run plus a `go` pulse in DONE → no second run until IDLE; a held `go` restarts exactly at the first IDLE cycle.
- STEP_CYCLES=1, ROUNDS=2 → sync high on T+1, T+2 and T+3; done at T+4.
